// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - iteration controller for the CORDIC rotation datapath
// Turns the comp level into a single start event and walks LOAD -> ITER(i=0..N_ITER-1) -> DONE.
module cordic_sequencer #(
    parameter int N_ITER = 16,
    parameter int IW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          comp,
    input  logic          abort,
    output logic [IW-1:0] i,
    output logic          load,
    output logic          en,
    output logic          stop,
    output logic          busy,
    output logic          done,
    output logic          result_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IW-1:0] I_LAST = IW'(N_ITER - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] i_nxt;
    logic          rv_nxt;
    logic          s1;
    logic          s2;
    logic          s2_d;
    logic          start;

    // comp is an unsynchronised switch level; only its rising edge starts a run
    assign start = s2 & ~s2_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s2_d         <= 1'b0;
            state        <= IDLE;
            i            <= '0;
            result_valid <= 1'b0;
        end else begin
            s1           <= comp;
            s2           <= s1;
            s2_d         <= s2;
            state        <= state_nxt;
            i            <= i_nxt;
            result_valid <= rv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        rv_nxt    = result_valid;
        case (state)
            IDLE: begin
                i_nxt = '0;
                if (start) begin
                    state_nxt = LOAD;
                    rv_nxt    = 1'b0;
                end
            end
            LOAD: begin
                i_nxt = '0;
                if (abort) begin
                    state_nxt = IDLE;
                    rv_nxt    = 1'b0;
                end else begin
                    state_nxt = ITER;
                end
            end
            ITER: begin
                // abort wins over the final-iteration transition
                if (abort) begin
                    state_nxt = IDLE;
                    i_nxt     = '0;
                    rv_nxt    = 1'b0;
                end else if (i == I_LAST) begin
                    state_nxt = DONE;
                    rv_nxt    = 1'b1;
                end else begin
                    i_nxt = i + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                i_nxt     = '0;
            end
            default: begin
                state_nxt = IDLE;
                i_nxt     = '0;
            end
        endcase
    end

    assign load = (state == LOAD);
    assign en   = (state == ITER);
    assign stop = ~(load | en);
    assign busy = load | en;
    assign done = (state == DONE);

endmodule
